// File: rtl/tsu_mport.sv
// Multi-port PTP timestamp unit: per-port SOP time capture, EOP keep/tag,
// round-robin merge of one-deep per-port slots into a shared show-ahead queue.

module tsu_mport_lane #(
  parameter int TAG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl,
  input  logic             keep,
  input  logic [TAG_W-1:0] tag,
  input  logic [47:0]      comp_sec,
  input  logic [31:0]      comp_ns,
  input  logic             grant,
  output logic             pending,
  output logic [TAG_W-1:0] slot_tag,
  output logic [47:0]      slot_sec,
  output logic [31:0]      slot_ns,
  output logic             drop
);
  logic        prev;
  logic [47:0] cap_sec;
  logic [31:0] cap_ns;
  logic        sop, eop, accept;

  assign sop    = ctrl & ~prev;
  assign eop    = ~ctrl & prev;
  // A slot being granted this cycle frees up in time to take the new entry.
  assign accept = eop & keep & (~pending | grant);
  assign drop   = eop & keep & pending & ~grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= 1'b0;
      cap_sec  <= '0;
      cap_ns   <= '0;
      pending  <= 1'b0;
      slot_tag <= '0;
      slot_sec <= '0;
      slot_ns  <= '0;
    end else begin
      prev <= ctrl;
      if (sop) begin
        cap_sec <= comp_sec;
        cap_ns  <= comp_ns;
      end
      if (accept) begin
        pending  <= 1'b1;
        slot_tag <= tag;
        slot_sec <= cap_sec;
        slot_ns  <= cap_ns;
      end else if (grant) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

module tsu_mport #(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       port_ctrl,
  input  logic [NUM_PORTS-1:0]       port_keep,
  input  logic [NUM_PORTS*TAG_W-1:0] port_tag,
  input  logic [79:0]                rtc_timer_in,
  input  logic [31:0]                ts_offset_ns,
  input  logic                       q_rd_en,
  output logic [8+TAG_W+79:0]        q_rd_data,
  output logic [8:0]                 q_rd_stat,
  output logic [7:0]                 drop_cnt
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

  typedef struct packed {
    logic [7:0]       port;
    logic [TAG_W-1:0] tag;
    logic [47:0]      sec;
    logic [31:0]      ns;
  } entry_t;

  // Both operands are below 1e9, so the sum fits in 32 bits.
  logic [31:0] ns_sum, comp_ns;
  logic [47:0] comp_sec;

  always_comb begin
    ns_sum   = rtc_timer_in[31:0] + ts_offset_ns;
    comp_sec = rtc_timer_in[79:32];
    comp_ns  = ns_sum;
    if (ns_sum >= NS_PER_SEC) begin
      comp_ns  = ns_sum - NS_PER_SEC;
      comp_sec = rtc_timer_in[79:32] + 48'd1;
    end
  end

  logic [NUM_PORTS-1:0]             pending, grant, drop;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  slot_tag;
  logic [NUM_PORTS-1:0][47:0]       slot_sec;
  logic [NUM_PORTS-1:0][31:0]       slot_ns;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    tsu_mport_lane #(.TAG_W(TAG_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ctrl     (port_ctrl[i]),
      .keep     (port_keep[i]),
      .tag      (port_tag[i*TAG_W +: TAG_W]),
      .comp_sec (comp_sec),
      .comp_ns  (comp_ns),
      .grant    (grant[i]),
      .pending  (pending[i]),
      .slot_tag (slot_tag[i]),
      .slot_sec (slot_sec[i]),
      .slot_ns  (slot_ns[i]),
      .drop     (drop[i])
    );
  end

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [8:0]    count;
  logic          full, rd, wr;
  logic [PW-1:0] last_grant, gnt_idx, cand;
  logic          gnt_vld;
  int            idx;

  assign full = (count == 9'(FIFO_DEPTH));
  assign rd   = q_rd_en && (count != 9'd0);
  assign wr   = gnt_vld;

  // Round-robin search begins one past the last winner; full blocks all grants.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    idx     = 0;
    cand    = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      cand = PW'(idx);
      if (!gnt_vld && !full && pending[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  entry_t mem [FIFO_DEPTH];
  entry_t wr_entry;

  assign wr_entry = '{port: 8'(gnt_idx), tag: slot_tag[gnt_idx],
                      sec: slot_sec[gnt_idx], ns: slot_ns[gnt_idx]};

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_entry;
  end

  logic [3:0] ndrop;
  logic [8:0] drop_sum;

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NUM_PORTS; i++) ndrop = ndrop + 4'(drop[i]);
    drop_sum = {1'b0, drop_cnt} + 9'(ndrop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= PW'(NUM_PORTS - 1);
      drop_cnt   <= '0;
    end else begin
      if (wr) begin
        wr_ptr     <= wr_ptr + AW'(1);
        last_grant <= gnt_idx;
      end
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + 9'd1;
        2'b01:   count <= count - 9'd1;
        default: count <= count;
      endcase
      drop_cnt <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    end
  end

  assign q_rd_stat = count;
  assign q_rd_data = (count == 9'd0) ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_tsu_mport.sv
// Scoreboard bench for tsu_mport: expected entries queued at EOP, compared on pop.

module tb_tsu_mport;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   ctrl = '0, keep = '0;
  logic [63:0]  tag = '0;
  logic [79:0]  rtc = '0;
  logic [31:0]  off = '0;
  logic         rd_en = 1'b0;
  logic [103:0] q_rd_data;
  logic [8:0]   q_rd_stat;
  logic [7:0]   drop_cnt;

  int errs = 0;
  int checks = 0;
  logic [103:0] sb[$];

  tsu_mport #(.NUM_PORTS(4), .FIFO_DEPTH(16), .TAG_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .port_ctrl    (ctrl),
    .port_keep    (keep),
    .port_tag     (tag),
    .rtc_timer_in (rtc),
    .ts_offset_ns (off),
    .q_rd_en      (rd_en),
    .q_rd_data    (q_rd_data),
    .q_rd_stat    (q_rd_stat),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string t, input logic [103:0] got, input logic [103:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] comp(input logic [79:0] r, input logic [31:0] o);
    logic [32:0] s;
    s = {1'b0, r[31:0]} + {1'b0, o};
    if (s >= 33'd1_000_000_000) return {r[79:32] + 48'd1, 32'(s - 33'd1_000_000_000)};
    return {r[79:32], s[31:0]};
  endfunction

  task automatic frame(input logic [3:0] m, input logic [3:0] k, input int len, input bit push);
    logic [79:0] c;
    ctrl = ctrl | m;
    c = comp(rtc, off);
    tick();
    repeat (len - 1) tick();
    ctrl = ctrl & ~m;
    keep = k;
    tick();
    keep = '0;
    if (push)
      for (int p = 0; p < 4; p++)
        if (m[p] && k[p]) sb.push_back({8'(p), tag[p*16 +: 16], c});
  endtask

  task automatic pop_check(input string t);
    if (sb.size() == 0) chk({t, "_sb_underflow"}, q_rd_data, 104'h0 - 104'h1);
    else chk(t, q_rd_data, sb.pop_front());
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_stat", q_rd_stat, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_data", q_rd_data, 0);
    rst = 1'b0;
    tick();

    // basic latency and compensation
    rtc = {48'd5, 32'd100}; off = 32'd20; tag[15:0] = 16'h1234;
    frame(4'b0001, 4'b0001, 3, 1'b1);
    chk("lat_k", q_rd_stat, 0);
    tick();
    chk("lat_k1", q_rd_stat, 1);
    chk("basic_data", q_rd_data, {8'h00, 16'h1234, 48'd5, 32'd120});
    pop_check("basic_pop");
    chk("basic_empty", q_rd_stat, 0);

    // keep=0 produces nothing
    frame(4'b0001, 4'b0000, 2, 1'b0);
    repeat (2) tick();
    chk("nokeep_stat", q_rd_stat, 0);
    chk("nokeep_drop", drop_cnt, 0);

    // ns rollover with 48-bit seconds wrap
    rtc = {48'hFFFF_FFFF_FFFF, 32'd999_999_990}; tag[63:48] = 16'hBEEF;
    frame(4'b1000, 4'b1000, 2, 1'b1);
    tick();
    chk("wrap_data", q_rd_data, {8'd3, 16'hBEEF, 48'd0, 32'd10});
    pop_check("wrap_pop");

    // simultaneous bursts, round-robin order twice
    for (int b = 0; b < 2; b++) begin
      rtc = {48'd100 + 48'(b), 32'd4000};
      tag = {16'hD003, 16'hC002, 16'hB001, 16'hA000} + 64'(b);
      frame(4'hF, 4'hF, 2, 1'b1);
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("burst_stat", q_rd_stat, 9'(i + 1));
      end
      for (int p = 0; p < 4; p++) begin
        chk("burst_ord", q_rd_data[103:96], 104'(p));
        pop_check("burst_pop");
      end
    end

    // fill queue to 16
    for (int b = 0; b < 4; b++) begin
      rtc = {48'd200, 32'd1000 * 32'(b)};
      tag = {16'(b * 4 + 3), 16'(b * 4 + 2), 16'(b * 4 + 1), 16'(b * 4)};
      frame(4'hF, 4'hF, 1, 1'b1);
      repeat (4) tick();
    end
    chk("fill_stat", q_rd_stat, 16);

    // full: pending held without drop, written after one pop
    tag[47:32] = 16'h2222; rtc = {48'd300, 32'd77};
    frame(4'b0100, 4'b0100, 1, 1'b1);
    repeat (3) tick();
    chk("full_hold", q_rd_stat, 16);
    chk("full_nodrop", drop_cnt, 0);
    pop_check("full_pop");
    chk("full_after_rd", q_rd_stat, 15);
    tick();
    chk("full_refill", q_rd_stat, 16);
    chk("full_drop0", drop_cnt, 0);

    // drops while full, then saturation
    tag[31:16] = 16'h1111;
    frame(4'b0010, 4'b0010, 1, 1'b1);
    frame(4'b0010, 4'b0010, 1, 1'b0);
    tick();
    chk("drop_one", drop_cnt, 1);
    for (int n = 0; n < 299; n++) frame(4'b0010, 4'b0010, 1, 1'b0);
    tick();
    chk("drop_sat", drop_cnt, 255);
    chk("drop_stat", q_rd_stat, 16);

    // drain everything with overlapping write of the held slot
    for (int n = 0; n < 40 && q_rd_stat != 0; n++) pop_check("drain");
    tick();
    chk("drain_stat", q_rd_stat, 0);
    chk("drain_sb", 104'(sb.size()), 0);

    // reset with queued and pending entries, mid-frame on port 0
    tag = 64'h4444_3333_2222_1111;
    frame(4'hF, 4'hF, 1, 1'b1);
    repeat (4) tick();
    frame(4'b0001, 4'b0001, 1, 1'b1);
    tick();
    chk("pre_rst_stat", q_rd_stat, 5);
    frame(4'b1110, 4'b1110, 1, 1'b0);
    ctrl[0] = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_stat", q_rd_stat, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_data", q_rd_data, 0);
    sb.delete();
    rtc = {48'd7, 32'd500}; off = 32'd0;
    tick();
    rst = 1'b0;
    tick();
    rtc = {48'd9, 32'd9};
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("empty_rd", q_rd_stat, 0);
    tag[15:0] = 16'h5A5A;
    ctrl[0] = 1'b0; keep = 4'b0001;
    sb.push_back({8'd0, 16'h5A5A, 48'd7, 32'd500});
    tick();
    keep = '0;
    chk("post_rst_k", q_rd_stat, 0);
    tick();
    chk("post_rst_k1", q_rd_stat, 1);
    chk("post_rst_drop", drop_cnt, 0);
    pop_check("post_rst_pop");

    // frame that never ends
    ctrl[2] = 1'b1; keep[2] = 1'b1;
    repeat (6) tick();
    chk("noend_stat", q_rd_stat, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
